// File: rtl/noc_flit_rx_ni_if.sv
`default_nettype none
// ============================================================================
//  Module      : noc_flit_rx_ni_if
//  Description : Handshake bundle for the flit receive network interface.
//                Carries the incoming 16-bit flit link and the outgoing
//                local valid/ready payload port.
//  Ports       : flit_in_data/flit_in_valid/flit_in_ready  - link side
//                rx_payload/rx_bcast/rx_valid/rx_ready      - local side
//  Modports    : master - environment (link transmitter + local consumer)
//                slave  - the receive NI itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface noc_flit_rx_ni_if;
  logic [15:0] flit_in_data;
  logic        flit_in_valid;
  logic        flit_in_ready;
  logic [9:0]  rx_payload;
  logic        rx_bcast;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output flit_in_data, flit_in_valid, rx_ready,
    input  flit_in_ready, rx_payload, rx_bcast, rx_valid
  );

  modport slave (
    input  flit_in_data, flit_in_valid, rx_ready,
    output flit_in_ready, rx_payload, rx_bcast, rx_valid
  );
endinterface
`default_nettype wire

// File: rtl/noc_flit_rx_ni.sv
`default_nettype none
// ============================================================================
//  Module      : noc_flit_rx_ni
//  Description : Receive-side network interface. Filters incoming flits
//                {dest[5:0], payload[9:0]} by destination, buffers matching
//                payloads in a first-word-fall-through FIFO and keeps
//                saturating accept/drop statistics.
//  Ports       : ACLK, ARESET  - clock, asynchronous active-high reset
//                link          - flit input and local rx output handshakes
//                stat_clr      - synchronous clear of the statistics
//                fifo_count    - current FIFO occupancy
//                accept_count  - flits stored since reset/clear
//                drop_count    - flits discarded since reset/clear
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_flit_rx_ni #(
  parameter logic [5:0] NODE_ID  = 6'd3,
  parameter logic [5:0] BCAST_ID = 6'h3F,
  parameter int         DEPTH    = 4,
  parameter int         CNT_W    = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  noc_flit_rx_ni_if.slave          link,
  input  logic                     stat_clr,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         accept_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int             AW     = $clog2(DEPTH);
  localparam int             CW     = AW + 1;
  localparam logic [CW-1:0]  C_FULL = CW'(DEPTH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [10:0]      r_mem [DEPTH];
  logic [CNT_W-1:0] r_accept_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [5:0] w_dest;
  logic       w_is_bcast;
  logic       w_match;
  logic       w_in_ready;
  logic       w_take;
  logic       w_push;
  logic       w_drop;
  logic       w_rx_valid;
  logic       w_pop;

  assign w_dest     = link.flit_in_data[15:10];
  assign w_is_bcast = (w_dest == BCAST_ID);
  assign w_match    = (w_dest == NODE_ID) || w_is_bcast;

  // Readiness looks only at occupancy (and reset), never at the offered
  // flit, so a full FIFO stalls wrong-destination flits as well.
  assign w_in_ready = !ARESET && (r_count != C_FULL);
  assign w_take     = link.flit_in_valid && w_in_ready;
  assign w_push     = w_take && w_match;
  assign w_drop     = w_take && !w_match;

  assign w_rx_valid = (r_count != '0);
  assign w_pop      = w_rx_valid && link.rx_ready;

  // Storage is plain RAM without reset; the head is masked to zero while
  // empty so the outputs read as zero after reset.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_is_bcast, link.flit_in_data[9:0]};
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Statistics: clear wins over a same-cycle increment; both saturate.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_accept_cnt <= '0;
      r_drop_cnt   <= '0;
    end else if (stat_clr) begin
      r_accept_cnt <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_push && (r_accept_cnt != '1)) begin
        r_accept_cnt <= r_accept_cnt + CNT_W'(1);
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign link.flit_in_ready = w_in_ready;
  assign link.rx_valid      = w_rx_valid;
  assign link.rx_payload    = w_rx_valid ? r_mem[r_rd_ptr][9:0] : '0;
  assign link.rx_bcast      = w_rx_valid ? r_mem[r_rd_ptr][10]  : 1'b0;

  assign fifo_count   = r_count;
  assign accept_count = r_accept_cnt;
  assign drop_count   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_noc_flit_rx_ni.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_flit_rx_ni
//  Description : Directed self-checking bench for noc_flit_rx_ni
//                (NODE_ID = 3, BCAST_ID = 6'h3F, DEPTH = 4, CNT_W = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_flit_rx_ni;

  localparam logic [5:0] NODE = 6'd3;
  localparam logic [5:0] BAD  = 6'd4;

  logic        ACLK;
  logic        ARESET;
  logic        stat_clr;
  logic [2:0]  fifo_count;
  logic [15:0] accept_count;
  logic [15:0] drop_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  noc_flit_rx_ni_if bus_if ();

  noc_flit_rx_ni #(
    .NODE_ID  (6'd3),
    .BCAST_ID (6'h3F),
    .DEPTH    (4),
    .CNT_W    (16)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .link         (bus_if),
    .stat_clr     (stat_clr),
    .fifo_count   (fifo_count),
    .accept_count (accept_count),
    .drop_count   (drop_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    stat_clr = 1'b0;
    bus_if.rx_ready = 1'b0;
    bus_if.flit_in_valid = 1'b1;
    bus_if.flit_in_data = {NODE, 10'h001};
    repeat (2) tick();
    total_cnt++; if (bus_if.flit_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus_if.flit_in_ready); else pass_cnt++;
    bus_if.flit_in_valid = 1'b0;
    ARESET = 1'b0;
    #1;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else pass_cnt++;
    total_cnt++; if (bus_if.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", bus_if.rx_valid); else pass_cnt++;
    total_cnt++; if (bus_if.rx_payload !== 10'h000) $display("FAIL reset_payload: got %h expected 000", bus_if.rx_payload); else pass_cnt++;
    total_cnt++; if (bus_if.rx_bcast !== 1'b0) $display("FAIL reset_bcast: got %b expected 0", bus_if.rx_bcast); else pass_cnt++;
    total_cnt++; if (accept_count !== 16'h0 || drop_count !== 16'h0) $display("FAIL reset_stats: got acc=%h drop=%h expected 0/0", accept_count, drop_count); else pass_cnt++;
    total_cnt++; if (bus_if.flit_in_ready !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", bus_if.flit_in_ready); else pass_cnt++;
  endtask

  task automatic test_single();
    bus_if.flit_in_data = 16'h0D23;
    bus_if.flit_in_valid = 1'b1;
    bus_if.rx_ready = 1'b1;
    #1;
    total_cnt++; if (bus_if.rx_valid !== 1'b0) $display("FAIL single_no_bypass: got %b expected 0", bus_if.rx_valid); else pass_cnt++;
    tick();
    bus_if.flit_in_valid = 1'b0;
    #1;
    total_cnt++; if (bus_if.rx_valid !== 1'b1) $display("FAIL single_rx_valid: got %b expected 1", bus_if.rx_valid); else pass_cnt++;
    total_cnt++; if (bus_if.rx_payload !== 10'h123 || bus_if.rx_bcast !== 1'b0) $display("FAIL single_head: got %h/%b expected 123/0", bus_if.rx_payload, bus_if.rx_bcast); else pass_cnt++;
    total_cnt++; if (accept_count !== 16'd1 || fifo_count !== 3'd1) $display("FAIL single_counts: got acc=%0d cnt=%0d expected 1/1", accept_count, fifo_count); else pass_cnt++;
    tick();
    total_cnt++; if (fifo_count !== 3'd0 || bus_if.rx_valid !== 1'b0) $display("FAIL single_drain: got cnt=%0d valid=%b expected 0/0", fifo_count, bus_if.rx_valid); else pass_cnt++;
  endtask

  task automatic test_filter();
    clear_stats();
    total_cnt++; if (accept_count !== 16'd0 || drop_count !== 16'd0) $display("FAIL filter_clr: got %0d/%0d expected 0/0", accept_count, drop_count); else pass_cnt++;
    bus_if.rx_ready = 1'b1;
    bus_if.flit_in_data = 16'h1123;
    bus_if.flit_in_valid = 1'b1;
    tick();
    bus_if.flit_in_data = 16'hFC55;
    #1;
    total_cnt++; if (drop_count !== 16'd1 || bus_if.rx_valid !== 1'b0) $display("FAIL filter_drop: got drop=%0d valid=%b expected 1/0", drop_count, bus_if.rx_valid); else pass_cnt++;
    tick();
    bus_if.flit_in_valid = 1'b0;
    #1;
    total_cnt++; if (bus_if.rx_valid !== 1'b1 || bus_if.rx_payload !== 10'h055 || bus_if.rx_bcast !== 1'b1) $display("FAIL filter_bcast: got v=%b p=%h b=%b expected 1/055/1", bus_if.rx_valid, bus_if.rx_payload, bus_if.rx_bcast); else pass_cnt++;
    total_cnt++; if (accept_count !== 16'd1 || drop_count !== 16'd1) $display("FAIL filter_stats: got %0d/%0d expected 1/1", accept_count, drop_count); else pass_cnt++;
    tick();
  endtask

  task automatic test_full();
    int exp_pl;
    int nxt;
    bit took;
    clear_stats();
    bus_if.rx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus_if.flit_in_data = {NODE, 10'(i)};
      bus_if.flit_in_valid = 1'b1;
      tick();
    end
    bus_if.flit_in_data = {NODE, 10'd5};
    #1;
    total_cnt++; if (fifo_count !== 3'd4 || bus_if.flit_in_ready !== 1'b0) $display("FAIL full_state: got cnt=%0d rdy=%b expected 4/0", fifo_count, bus_if.flit_in_ready); else pass_cnt++;
    tick();
    // A non-matching flit must stall too while full.
    bus_if.flit_in_data = {BAD, 10'h3FF};
    tick();
    total_cnt++; if (accept_count !== 16'd4 || drop_count !== 16'd0 || fifo_count !== 3'd4) $display("FAIL full_stall: got acc=%0d drop=%0d cnt=%0d expected 4/0/4", accept_count, drop_count, fifo_count); else pass_cnt++;
    total_cnt++; if (bus_if.rx_payload !== 10'd1) $display("FAIL full_hold: got %h expected 001", bus_if.rx_payload); else pass_cnt++;
    bus_if.rx_ready = 1'b1;
    exp_pl = 1;
    nxt = 5;
    for (int cyc = 0; cyc < 20 && exp_pl <= 6; cyc++) begin
      bus_if.flit_in_valid = (nxt <= 6);
      bus_if.flit_in_data = {NODE, 10'(nxt)};
      #1;
      if (cyc == 0) begin
        total_cnt++; if (bus_if.flit_in_ready !== 1'b0) $display("FAIL full_ready_pop0: got %b expected 0", bus_if.flit_in_ready); else pass_cnt++;
      end
      if (cyc == 1) begin
        total_cnt++; if (bus_if.flit_in_ready !== 1'b1) $display("FAIL full_ready_pop1: got %b expected 1", bus_if.flit_in_ready); else pass_cnt++;
      end
      took = bus_if.flit_in_valid && bus_if.flit_in_ready;
      if (bus_if.rx_valid) begin
        total_cnt++; if (bus_if.rx_payload !== 10'(exp_pl)) $display("FAIL full_order: got %h expected %h", bus_if.rx_payload, 10'(exp_pl)); else pass_cnt++;
        exp_pl++;
      end
      tick();
      if (took) nxt++;
    end
    bus_if.flit_in_valid = 1'b0;
    #1;
    total_cnt++; if (exp_pl != 7 || nxt != 7 || fifo_count !== 3'd0) $display("FAIL full_complete: got popped=%0d sent=%0d cnt=%0d expected 6/6/0", exp_pl - 1, nxt - 1, fifo_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus_if.rx_ready = 1'b0;
    bus_if.flit_in_valid = 1'b1;
    bus_if.flit_in_data = {NODE, 10'h010};
    tick();
    bus_if.flit_in_data = {NODE, 10'h011};
    tick();
    bus_if.rx_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus_if.flit_in_data = {NODE, 10'(16'h12 + k)};
      #1;
      total_cnt++; if (fifo_count !== 3'd2 || bus_if.rx_payload !== 10'(16'h10 + k)) $display("FAIL b2b_step%0d: got cnt=%0d head=%h expected 2/%h", k, fifo_count, bus_if.rx_payload, 10'(16'h10 + k)); else pass_cnt++;
      tick();
    end
    bus_if.flit_in_valid = 1'b0;
    #1;
    total_cnt++; if (bus_if.rx_payload !== 10'h01A) $display("FAIL b2b_tail0: got %h expected 01A", bus_if.rx_payload); else pass_cnt++;
    tick();
    total_cnt++; if (bus_if.rx_payload !== 10'h01B || fifo_count !== 3'd1) $display("FAIL b2b_tail1: got %h cnt=%0d expected 01B/1", bus_if.rx_payload, fifo_count); else pass_cnt++;
    tick();
    total_cnt++; if (bus_if.rx_valid !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", bus_if.rx_valid); else pass_cnt++;
  endtask

  task automatic test_saturate();
    clear_stats();
    bus_if.rx_ready = 1'b1;
    bus_if.flit_in_data = {BAD, 10'h000};
    bus_if.flit_in_valid = 1'b1;
    repeat (65534) tick();
    total_cnt++; if (drop_count !== 16'hFFFE) $display("FAIL sat_preload: got %h expected FFFE", drop_count); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (drop_count !== 16'hFFFF || accept_count !== 16'h0) $display("FAIL sat_hold: got drop=%h acc=%h expected FFFF/0000", drop_count, accept_count); else pass_cnt++;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    bus_if.flit_in_valid = 1'b0;
    #1;
    total_cnt++; if (drop_count !== 16'h0) $display("FAIL sat_clr_drop: got %h expected 0000", drop_count); else pass_cnt++;
    // Clear with a matching flit: count lost, FIFO still receives it.
    bus_if.flit_in_data = {NODE, 10'h077};
    bus_if.flit_in_valid = 1'b1;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    bus_if.flit_in_valid = 1'b0;
    #1;
    total_cnt++; if (accept_count !== 16'h0 || bus_if.rx_payload !== 10'h077) $display("FAIL sat_clr_accept: got acc=%h head=%h expected 0000/077", accept_count, bus_if.rx_payload); else pass_cnt++;
    tick();
  endtask

  task automatic test_async_reset();
    bus_if.rx_ready = 1'b0;
    bus_if.flit_in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus_if.flit_in_data = {NODE, 10'(16'h20 + i)};
      tick();
    end
    bus_if.flit_in_data = {NODE, 10'h0AA};
    #1;
    total_cnt++; if (fifo_count !== 3'd3) $display("FAIL arst_fill: got %0d expected 3", fifo_count); else pass_cnt++;
    ARESET = 1'b1;
    #1;
    total_cnt++; if (bus_if.rx_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL arst_async: got valid=%b cnt=%0d expected 0/0", bus_if.rx_valid, fifo_count); else pass_cnt++;
    total_cnt++; if (bus_if.flit_in_ready !== 1'b0) $display("FAIL arst_ready: got %b expected 0", bus_if.flit_in_ready); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if (fifo_count !== 3'd0 || accept_count !== 16'h0) $display("FAIL arst_hold: got cnt=%0d acc=%0d expected 0/0", fifo_count, accept_count); else pass_cnt++;
    bus_if.flit_in_valid = 1'b0;
    ARESET = 1'b0;
    #1;
    bus_if.flit_in_data = 16'h0C2A;
    bus_if.flit_in_valid = 1'b1;
    bus_if.rx_ready = 1'b1;
    tick();
    bus_if.flit_in_valid = 1'b0;
    #1;
    total_cnt++; if (bus_if.rx_valid !== 1'b1 || bus_if.rx_payload !== 10'h02A || accept_count !== 16'd1) $display("FAIL arst_after: got v=%b p=%h acc=%0d expected 1/02A/1", bus_if.rx_valid, bus_if.rx_payload, accept_count); else pass_cnt++;
    tick();
  endtask

  initial begin
    ARESET = 1'b1;
    stat_clr = 1'b0;
    bus_if.flit_in_data = 16'h0;
    bus_if.flit_in_valid = 1'b0;
    bus_if.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_filter();
    test_full();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
